// File: rtl/fetch_pc_unit_if.sv
// Fetch front-end bus: imem request/response, decode hand-off, and control
// inputs (stall/redirect) plus the exported fetch PC.
// master = fetch unit side, slave = environment (imem + decode + control).
interface fetch_pc_unit_if #(
   parameter int unsigned PC_W    = 6,
   parameter int unsigned INSTR_W = 16
);
   // imem request channel
   logic               req_valid;
   logic               req_ready;
   logic [PC_W-1:0]    req_addr;
   // imem response channel (in order, no backpressure)
   logic               rsp_valid;
   logic [INSTR_W-1:0] rsp_data;
   // decode channel
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   // control
   logic               stall;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic [PC_W-1:0]    pcout;

   modport master (
      output req_valid, req_addr, out_valid, out_instr, out_pc, pcout,
      input  req_ready, rsp_valid, rsp_data, out_ready, stall, redirect, redirect_pc
   );

   modport slave (
      input  req_valid, req_addr, out_valid, out_instr, out_pc, pcout,
      output req_ready, rsp_valid, rsp_data, out_ready, stall, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word-addressed
// requests under a credit limit, queues in-order responses tagged with their
// PC, and hands them to decode. Redirect flushes the queue and discards any
// responses still in flight.
// Optional feature macro: FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_pc_unit #(
   parameter int unsigned PC_W     = 6,
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned QDEPTH   = 2,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            reset,
   fetch_pc_unit_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]     perf_stall_cnt,
   output logic [15:0]     perf_flush_cnt
`endif
);

   localparam int unsigned CW = $clog2(QDEPTH + 1);
   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

   // Architectural state
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      outst_q, outst_d;
   logic [CW-1:0]      drop_q, drop_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [INSTR_W-1:0] instr_q [QDEPTH];
   logic [PC_W-1:0]    epc_q   [QDEPTH];

   // Decoded events for this cycle
   logic          credit;
   logic          accept;
   logic          dropping;
   logic          push;
   logic          pop;
   logic [CW:0]   in_use;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit, handshakes and queue-head outputs
   always_comb begin
      in_use    = {1'b0, count_q} + {1'b0, outst_q};
      credit    = (in_use < (CW + 1)'(QDEPTH));
      // reset gates req_valid so nothing is requested while held in reset
      bus.req_valid = reset & ~bus.stall & ~bus.redirect & credit;
      bus.req_addr  = pc_q;
      bus.pcout     = pc_q;
      bus.out_valid = (count_q != '0);
      bus.out_instr = instr_q[rd_ptr_q];
      bus.out_pc    = epc_q[rd_ptr_q];
      accept    = bus.req_valid & bus.req_ready;
      dropping  = bus.rsp_valid & (drop_q != '0);
      push      = bus.rsp_valid & (drop_q == '0) & ~bus.redirect;
      pop       = bus.out_valid & bus.out_ready & ~bus.redirect;
   end

   // Next-state for PC, counters and queue pointers; redirect wins over all
   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      count_d  = count_q;
      outst_d  = outst_q + CW'(accept) - CW'(bus.rsp_valid);
      drop_d   = drop_q - CW'(dropping);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (bus.redirect) begin
         pc_d     = bus.redirect_pc;
         rsp_pc_d = bus.redirect_pc;
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         // Every request still in flight after this cycle is stale. Responses
         // already marked for dropping are part of outst_q, so they are not
         // added a second time.
         drop_d   = outst_q - CW'(bus.rsp_valid);
      end else begin
         if (accept) begin
            pc_d = pc_q + 1'b1;
         end
         if (push) begin
            rsp_pc_d = rsp_pc_q + 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RST_PC;
         rsp_pc_q <= RST_PC;
         count_q  <= '0;
         outst_q  <= '0;
         drop_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         count_q  <= count_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Queue storage; entries reset so the head reads 0 / RESET_PC in reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(QDEPTH); i++) begin
            instr_q[i] <= '0;
            epc_q[i]   <= RST_PC;
         end
      end else if (push) begin
         instr_q[wr_ptr_q] <= bus.rsp_data;
         epc_q[wr_ptr_q]   <= rsp_pc_q;
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating performance counters: stalled-with-credit cycles and redirects
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (credit && bus.stall && (perf_stall_cnt != 16'hffff)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         end
         if (bus.redirect && (perf_flush_cnt != 16'hffff)) begin
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
         end
      end
   end
`endif

   // Protocol checks: a response must never land on a full queue, and never
   // arrive without a matching accepted request.
   a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
      !(push && !pop && (count_q == CW'(QDEPTH))));
   a_rsp_has_req : assert property (@(posedge clk) disable iff (!reset)
      !(bus.rsp_valid && (outst_q == '0)));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: an imem model with configurable latency,
// an epoch-tagged scoreboard of expected decode entries, and per-cycle checks
// of credit, PC and queue-head outputs.
module tb_fetch_pc_unit;

   localparam int PC_W    = 6;
   localparam int INSTR_W = 16;
   localparam int QDEPTH  = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   fetch_pc_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

`ifdef FETCH_PERF_EN
   logic [15:0] perf_stall_cnt;
   logic [15:0] perf_flush_cnt;
`endif

   fetch_pc_unit #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .QDEPTH   (QDEPTH),
      .RESET_PC (0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .bus            (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PC_W-1:0] addr;
      int              epoch;
      int              due;
   } req_t;

   typedef struct {
      logic [INSTR_W-1:0] data;
      logic [PC_W-1:0]    pc;
   } ent_t;

   req_t pend[$];   // accepted, response not yet delivered
   ent_t sb[$];     // expected decode entries, in order

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int epoch = 0;
   int lat   = 1;
   int pstall = 0;
   int pflush = 0;
   logic [PC_W-1:0] mpc = '0;
   logic [PC_W-1:0] first_pc = '0;
   bit watch = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [INSTR_W-1:0] fdata(input logic [PC_W-1:0] a);
      return {4'hc, a, ~a};
   endfunction

   // One clock cycle: drive imem response, check outputs, advance the model.
   task automatic tick();
      req_t r;
      ent_t e;
      logic rsp, acc, pop, rdr, exp_rv;
      rsp = (pend.size() != 0) && (pend[0].due <= cyc);
      bus.rsp_valid = rsp;
      bus.rsp_data  = rsp ? fdata(pend[0].addr) : '0;
      #3;
      rdr    = bus.redirect;
      exp_rv = !bus.stall && !rdr && ((sb.size() + pend.size()) < QDEPTH);
      check("req_valid", {31'd0, bus.req_valid}, {31'd0, exp_rv});
      check("pcout", 32'(bus.pcout), 32'(mpc));
      check("req_addr", 32'(bus.req_addr), 32'(mpc));
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
      if (sb.size() != 0) begin
         check("out_instr", 32'(bus.out_instr), 32'(sb[0].data));
         check("out_pc", 32'(bus.out_pc), 32'(sb[0].pc));
      end
      acc = bus.req_valid & bus.req_ready;
      pop = bus.out_valid & bus.out_ready;
      if (bus.stall && ((sb.size() + pend.size()) < QDEPTH)) pstall++;
      if (rdr) pflush++;
      if (pop && !rdr && watch) begin
         first_pc = bus.out_pc;
         watch    = 1'b0;
      end
      @(posedge clk);
      #1;
      if (rsp) r = pend.pop_front();
      if (rdr) begin
         sb.delete();
         epoch++;
         mpc = bus.redirect_pc;
      end else begin
         if (pop && sb.size() != 0) e = sb.pop_front();
         if (rsp && r.epoch == epoch) sb.push_back('{fdata(r.addr), r.addr});
         if (acc) begin
            pend.push_back('{mpc, epoch, cyc + lat});
            mpc = mpc + 1'b1;
         end
      end
      cyc++;
   endtask

   initial begin
      bus.req_ready   = 1'b1;
      bus.rsp_valid   = 1'b0;
      bus.rsp_data    = '0;
      bus.out_ready   = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;

      // Reset state
      #2;
      check("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_instr", 32'(bus.out_instr), 32'd0);
      check("rst_out_pc", 32'(bus.out_pc), 32'd0);
      check("rst_pcout", 32'(bus.pcout), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // 1: streaming fetch, long enough for the PC to wrap 63 -> 0
      repeat (140) tick();

      // 2: decode backpressure fills the queue, then drains in order
      bus.out_ready = 1'b0;
      repeat (6) tick();
      check("t2_full_req_valid", {31'd0, bus.req_valid}, 32'd0);
      check("t2_full_out_valid", {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b1;
      repeat (10) tick();

      // 3: redirect with two requests in flight
      lat = 3;
      for (int i = 0; i < 20 && pend.size() < 2; i++) tick();
      check("t3_two_in_flight", 32'(pend.size()), 32'd2);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 6'h20;
      watch           = 1'b1;
      tick();
      bus.redirect = 1'b0;
      check("t3_req_addr", 32'(bus.req_addr), 32'h20);
      repeat (15) tick();
      check("t3_first_out_pc", 32'(first_pc), 32'h20);
      lat = 1;

      // 4: stall with queued entries; they still drain
      bus.out_ready = 1'b0;
      repeat (4) tick();
      bus.stall     = 1'b1;
      bus.out_ready = 1'b1;
      repeat (5) begin
         tick();
         check("t4_stall_req_valid", {31'd0, bus.req_valid}, 32'd0);
      end
      check("t4_drained", {31'd0, bus.out_valid}, 32'd0);
      bus.stall = 1'b0;
      repeat (10) tick();

      // 5: asynchronous reset mid-burst
      bus.out_ready = 1'b0;
      repeat (3) tick();
      #2;
      reset         = 1'b0;
      bus.rsp_valid = 1'b0;
      #1;
      check("t5_req_valid", {31'd0, bus.req_valid}, 32'd0);
      check("t5_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t5_pcout", 32'(bus.pcout), 32'd0);
      sb.delete();
      pend.delete();
      epoch++;
      mpc    = '0;
      pstall = 0;
      pflush = 0;
      @(posedge clk);
      #1;
      reset         = 1'b1;
      bus.out_ready = 1'b1;
      repeat (20) tick();

      // 6: redirects and stalled cycles (counters checked when enabled)
      for (int k = 0; k < 3; k++) begin
         bus.redirect    = 1'b1;
         bus.redirect_pc = 6'(8 * k + 3);
         tick();
         bus.redirect = 1'b0;
         repeat (4) tick();
      end
      bus.stall = 1'b1;
      repeat (4) tick();
      bus.stall = 1'b0;
      repeat (6) tick();
`ifdef FETCH_PERF_EN
      check("t6_perf_flush", 32'(perf_flush_cnt), 32'(pflush));
      check("t6_perf_stall", 32'(perf_stall_cnt), 32'(pstall));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
